serial_word_shifter: RTL
========================

// Module: serial_word_shifter
// PURPOSE
//  Parallel-to-serial stage directly upstream of the serial pattern detectors ("10110" FSMs).
//  - Accepts WIDTH-bit words over a valid/ready handshake.
//  - Emits them one bit per clk on bit_out, with zero-bubble back-to-back words.
//  - The detector samples bit_out on every clk, so bit_out holds IDLE_LEVEL whenever no word is shifting.
// PARAMETERS
//  WIDTH       8   word width in bits; legal range 2..32
//  MSB_FIRST   1   1: bit[WIDTH-1] is sent first; 0: bit[0] is sent first
//  IDLE_LEVEL  0   value driven on bit_out while idle
// PORTS
//  clk         in   1      clock, rising edge
//  rst_n       in   1      synchronous, active-low reset
//  in_data     in   WIDTH  parallel word; sampled on handshake
//  in_valid    in   1      upstream offers in_data
//  in_ready    out  1      block can accept a word this cycle
//  bit_out     out  1      serial bit; connects to the detector's data_in
//  bit_valid   out  1      bit_out carries a word bit this cycle
//  word_start  out  1      pulse: bit_out is the first bit of a word
//  word_last   out  1      pulse: bit_out is the last bit of a word
//  busy        out  1      a word is being shifted (equals bit_valid)
// BEHAVIOUR
//  Reset (clk edge with rst_n=0): all outputs and registers are cleared.
//   - state=IDLE, cnt=0, shreg=0
//   - bit_out=IDLE_LEVEL; bit_valid, word_start, word_last, busy = 0
//   - A word in flight is dropped with no partial completion. in_ready=1 from the first cycle after reset release.
//  FSM states:
//   - IDLE: bit_valid=0. On in_valid&&in_ready: load shreg<=in_data, cnt<=0, go to SHIFT.
//   - SHIFT: bit_out=current bit, bit_valid=1. Each clk: cnt++ and shift by 1 toward the send end.
//     - At cnt==WIDTH-1 with in_valid: reload and stay in SHIFT (no gap).
//     - At cnt==WIDTH-1 without in_valid: go to IDLE.
//  Handshake:
//   - in_ready = (state==IDLE) | (state==SHIFT & cnt==WIDTH-1); combinational from registers only.
//   - Transfer occurs iff in_valid & in_ready at a rising clk edge.
//   - in_valid while !in_ready: word is held off; no drop, no overwrite.
//  Timing and outputs:
//   - Latency: first bit appears on bit_out in the cycle after the accepting edge.
//   - A word occupies exactly WIDTH consecutive bit_valid cycles.
//   - All outputs are registered (bit_out from the shreg end bit), except in_ready.
//   - word_start=1 when cnt==0 in SHIFT; word_last=1 when cnt==WIDTH-1 in SHIFT.
//   - word_start and word_last are never both high, since WIDTH>=2.
//  Counter rules:
//   - cnt is $clog2(WIDTH) bits.
//   - cnt never exceeds WIDTH-1; it wraps to 0 only via reload or IDLE.
//  Corner cases:
//   - in_valid toggling mid-word: ignored.
//   - in_data changing while not accepted: ignored.
//   - Reset asserted on the same edge as a handshake: reset wins; the word is not accepted.
// STRUCTURE
//  - serial_pkg (shared with the detectors): IDLE/SHIFT state localparams and the IDLE_LEVEL default.
//  - One natural sub-module: serial_bit_counter.
//    - Parameter WIDTH.
//    - Ports: clk, rst_n, clr, en, cnt, at_last.
//  - The top holds the FSM, the shift register and the output registers.
// TESTING
//  Bench drives the block and instantiates detecting_overlapp on bit_out.
//  1. Reset then send 8'hB0, MSB_FIRST=1 -> bit_out=1,0,1,1,0,0,0,0 on the 8 cycles after accept;
//     word_start on cycle 1, word_last on cycle 8; detector valid=1 on cycle 5.
//  2. in_valid held high with words 8'hB0, 8'h2C -> 16 contiguous bit_valid cycles;
//     in_ready=1 only on cycle 8; no gap between words.
//  3. MSB_FIRST=0, send 8'h0D -> bit_out=1,0,1,1,0,0,0,0 (LSB first).
//  4. rst_n=0 on bit 4 of 8'hFF -> next cycle bit_out=IDLE_LEVEL, bit_valid=0, in_ready=1;
//     the rest of the word is never emitted.
//  5. in_valid pulsed mid-word with 8'hAA -> not accepted (in_ready=0); the current word is unaffected.
//  6. Idle 10 cycles -> bit_out=0, bit_valid=0, busy=0; detector valid stays 0.

Source files
------------

// File: rtl/serial_word_shifter_pkg.sv
// Shared definitions for the serial stream blocks: FSM state encoding and the idle line level.
package serial_word_shifter_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

   localparam logic IDLE_LEVEL_DEFAULT = 1'b0;
   localparam int   WIDTH_DEFAULT      = 8;

endpackage

// File: rtl/serial_word_shifter_if.sv
// Word-in / bit-out bundle of the serial word shifter.
// The master is the upstream word source; the slave is the shifter.
interface serial_word_shifter_if #(
   parameter int WIDTH = 8
);

   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             bit_out;
   logic             bit_valid;
   logic             word_start;
   logic             word_last;
   logic             busy;

   modport master (
      output in_data, in_valid,
      input  in_ready, bit_out, bit_valid, word_start, word_last, busy
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, bit_out, bit_valid, word_start, word_last, busy
   );

endinterface

// File: rtl/serial_word_shifter_bit_counter.sv
// Bit position counter for the word being shifted; it saturates at WIDTH-1 and
// only returns to 0 through clr.
module serial_bit_counter #(
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clr,
   input  logic                     en,
   output logic [$clog2(WIDTH)-1:0] cnt,
   output logic                     at_last
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: clear wins, advance only below the last position
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = {CW{1'b0}};
      end else if (en && (cnt_q != LAST)) begin
         cnt_d = cnt_q + CW'(1'b1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= {CW{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt     = cnt_q;
   assign at_last = (cnt_q == LAST);

endmodule

// File: rtl/serial_word_shifter.sv
// Parallel-to-serial stage in front of the serial pattern detectors: takes WIDTH-bit
// words over valid/ready and emits them one bit per clk with no gap between words.
module serial_word_shifter
   import serial_word_shifter_pkg::*;
#(
   parameter int   WIDTH      = WIDTH_DEFAULT,
   parameter bit   MSB_FIRST  = 1'b1,
   parameter logic IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
   input logic                  clk,
   input logic                  rst_n,
   serial_word_shifter_if.slave bus
);

   localparam int CW       = $clog2(WIDTH);
   localparam int SEND_IDX = MSB_FIRST ? (WIDTH - 1) : 0;

   state_e           state_q;
   state_e           state_d;
   logic [WIDTH-1:0] shreg_q;
   logic [WIDTH-1:0] shreg_d;
   logic [WIDTH-1:0] shreg_shift_s;
   logic [CW-1:0]    cnt_s;
   logic             at_last_s;
   logic             in_ready_s;
   logic             load_s;
   logic             cnt_clr_s;
   logic             cnt_en_s;
   logic             bit_out_q;
   logic             bit_out_d;
   logic             bit_valid_q;
   logic             bit_valid_d;
   logic             word_start_q;
   logic             word_start_d;
   logic             word_last_q;
   logic             word_last_d;

   serial_bit_counter #(
      .WIDTH (WIDTH)
   ) u_bit_counter (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (cnt_clr_s),
      .en      (cnt_en_s),
      .cnt     (cnt_s),
      .at_last (at_last_s)
   );

   // The next word may be taken while the last bit of the current one is on the line.
   assign in_ready_s = (state_q == ST_IDLE) | ((state_q == ST_SHIFT) & at_last_s);
   assign load_s     = bus.in_valid & in_ready_s;

   generate
      if (MSB_FIRST) begin : g_msb_first
         assign shreg_shift_s = {shreg_q[WIDTH-2:0], 1'b0};
      end else begin : g_lsb_first
         assign shreg_shift_s = {1'b0, shreg_q[WIDTH-1:1]};
      end
   endgenerate

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (load_s) state_d = ST_SHIFT;
            else        state_d = ST_IDLE;
         end
         ST_SHIFT: begin
            if (at_last_s && !bus.in_valid) state_d = ST_IDLE;
            else                            state_d = ST_SHIFT;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: counter control, shift register update and next output values
   always_comb begin
      cnt_clr_s = 1'b0;
      cnt_en_s  = 1'b0;
      shreg_d   = shreg_q;
      if (load_s) begin
         cnt_clr_s = 1'b1;
         shreg_d   = bus.in_data;
      end else if ((state_q == ST_SHIFT) && at_last_s) begin
         cnt_clr_s = 1'b1;
         shreg_d   = {WIDTH{1'b0}};
      end else if (state_q == ST_SHIFT) begin
         cnt_en_s = 1'b1;
         shreg_d  = shreg_shift_s;
      end else begin
         shreg_d = shreg_q;
      end

      bit_valid_d = (state_d == ST_SHIFT);
      if (state_d == ST_SHIFT) begin
         bit_out_d = shreg_d[SEND_IDX];
      end else begin
         bit_out_d = IDLE_LEVEL;
      end
      // A load always starts a word; the last bit follows the second-to-last one.
      word_start_d = load_s;
      word_last_d  = (state_q == ST_SHIFT) && (cnt_s == CW'(WIDTH - 2));
   end

   // Shift register and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shreg_q      <= {WIDTH{1'b0}};
         bit_out_q    <= IDLE_LEVEL;
         bit_valid_q  <= 1'b0;
         word_start_q <= 1'b0;
         word_last_q  <= 1'b0;
      end else begin
         shreg_q      <= shreg_d;
         bit_out_q    <= bit_out_d;
         bit_valid_q  <= bit_valid_d;
         word_start_q <= word_start_d;
         word_last_q  <= word_last_d;
      end
   end

   assign bus.in_ready   = in_ready_s;
   assign bus.bit_out    = bit_out_q;
   assign bus.bit_valid  = bit_valid_q;
   assign bus.word_start = word_start_q;
   assign bus.word_last  = word_last_q;
   assign bus.busy       = bit_valid_q;

endmodule
